// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the buffered UART transmitter
// (and a future buffered receiver).
//   parity_e     - decoded parity selection (reserved encoding folds to NONE)
//   tx_state_e   - transmitter frame FSM states
//   PARITY_*     - raw encodings of the 2-bit parity_mode input
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_EVEN = 2'b01;
    localparam logic [1:0] PARITY_ODD  = 2'b10;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // Raw mode 2'b11 is reserved and behaves exactly like "no parity".
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            PARITY_NONE: return NONE;
            PARITY_EVEN: return EVEN;
            PARITY_ODD:  return ODD;
            default:     return NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: word handshake between the host logic and the UART TX.
//   data_tx   - word to transmit (BITS_N bits)
//   valid     - data_tx valid; accepted on a clock edge with valid && tx_ready
//   tx_ready  - transmitter FIFO can take a word
// master: host side, slave: transmitter side.
interface uart_tx_fifo_if #(
    parameter int BITS_N = 8
);
    logic [BITS_N-1:0] data_tx;
    logic              valid;
    logic              tx_ready;

    modport master (output data_tx, output valid, input tx_ready);
    modport slave  (input data_tx, input valid, output tx_ready);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, reset_n - clock, synchronous active-low reset (empties the FIFO)
//   push, din    - write request and data; ignored while full
//   pop, dout    - read request; dout always shows the head entry
//   full, empty  - occupancy flags (pure functions of registered count)
//   count        - entries held, 0..DEPTH
// DEPTH must be a power of 2 so the pointers wrap by natural overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with runtime frame configuration.
//   clk, reset_n - clock, synchronous active-low reset (aborts any frame)
//   tx           - slave side of the word handshake (data_tx/valid/tx_ready)
//   parity_mode  - 00 none, 01 even, 10 odd, 11 none; latched per frame
//   two_stop     - 1: two stop bits; latched per frame
//   uart_out     - registered serial line, idle high
//   busy         - frame in progress or words still buffered
//   fifo_count   - buffered words, excluding the one being shifted
// Frame: start, BITS_N data bits LSB first, optional parity, 1 or 2 stops.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    uart_tx_fifo_if.slave               tx,
    input  logic [1:0]                  parity_mode,
    input  logic                        two_stop,
    output logic                        uart_out,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int CNT_W = $clog2(2 * CLKS_PER_BIT) + 1;
    localparam int BN_W  = $clog2(BITS_N);
    localparam logic [CNT_W-1:0] ONE_BIT_END = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TWO_BIT_END = CNT_W'(2 * CLKS_PER_BIT - 1);
    localparam logic [BN_W-1:0]  LAST_BIT    = BN_W'(BITS_N - 1);

    tx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  baud_cnt;
    logic [BN_W-1:0]   bit_n, bit_nxt;
    logic [BITS_N-1:0] shift;
    parity_e           par_q;
    logic              two_stop_q;

    logic              fifo_full, fifo_empty, pop;
    logic [BITS_N-1:0] fifo_head;
    logic              bit_end, par_en, par_bit, uart_d;
    logic [CNT_W-1:0]  cnt_end;

    sync_fifo #(
        .WIDTH (BITS_N),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (tx.valid),
        .din     (tx.data_tx),
        .pop     (pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // The FIFO already drops pushes while full; ready mirrors that state.
    assign tx.tx_ready = !fifo_full;
    assign busy        = (state != IDLE) || !fifo_empty;

    assign par_en  = (par_q != NONE);
    assign par_bit = (par_q == ODD) ? ~^shift : ^shift;
    // Only the stop phase may stretch to two bit periods.
    assign cnt_end = (state == STOP && two_stop_q) ? TWO_BIT_END : ONE_BIT_END;
    assign bit_end = (baud_cnt == cnt_end);

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        bit_nxt   = '0;
        uart_d    = 1'b1;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START:  if (bit_end) state_nxt = DATA;
            DATA: begin
                bit_nxt = bit_end ? bit_n + 1'b1 : bit_n;
                if (bit_end && bit_n == LAST_BIT)
                    state_nxt = par_en ? PARITY : STOP;
            end
            PARITY: if (bit_end) state_nxt = STOP;
            STOP:   if (bit_end) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // Line level is computed for the upcoming cycle so uart_out can be
        // a plain register aligned with the state it belongs to.
        case (state_nxt)
            START:   uart_d = 1'b0;
            DATA:    uart_d = shift[bit_nxt];
            PARITY:  uart_d = par_bit;
            default: uart_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_n      <= '0;
            shift      <= '0;
            par_q      <= NONE;
            two_stop_q <= 1'b0;
            uart_out   <= 1'b1;
        end else begin
            state    <= state_nxt;
            bit_n    <= bit_nxt;
            uart_out <= uart_d;
            if (state_nxt != state || bit_end || state == IDLE)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            // Frame configuration freezes at pop time.
            if (pop) begin
                shift      <= fifo_head;
                par_q      <= decode_parity(parity_mode);
                two_stop_q <= two_stop;
            end
        end
    end
endmodule
